// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one 23-bit logical right barrel shifter between two requesters,
// with one registered result slot per port. Define SHIFTER_ARB_STICKY_EN to add sticky-bit outputs.

module barrel_shifter #(
    parameter int DATA_W  = 23,
    parameter int SHAMT_W = 5
) (
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result
`ifdef SHIFTER_ARB_STICKY_EN
    ,
    output logic               sticky
`endif
);
    localparam logic [SHAMT_W-1:0] SHAMT_LIM = SHAMT_W'(DATA_W);

    always_comb begin
        result = '0;
        if (shamt < SHAMT_LIM) result = data >> shamt;
    end

`ifdef SHIFTER_ARB_STICKY_EN
    logic [DATA_W-1:0] mask;

    // Bits that fall off the bottom; all of them once the shift reaches the width.
    always_comb begin
        mask = '1;
        if (shamt < SHAMT_LIM) mask = (DATA_W'(1) << shamt) - DATA_W'(1);
        sticky = |(data & mask);
    end
`endif
endmodule

module shifter_arbiter #(
    parameter int DATA_W  = 23,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_data,
    output logic [TAG_W-1:0]   rsp0_tag,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_data,
    output logic [TAG_W-1:0]   rsp1_tag
`ifdef SHIFTER_ARB_STICKY_EN
    ,
    output logic               rsp0_sticky,
    output logic               rsp1_sticky
`endif
);
    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} state_t;

    state_t             state, state_next;
    logic               elig0, elig1;
    logic               grant0, grant1;
    logic [DATA_W-1:0]  sh_data, sh_result;
    logic [SHAMT_W-1:0] sh_shamt;
    logic [TAG_W-1:0]   sh_tag;
`ifdef SHIFTER_ARB_STICKY_EN
    logic               sh_sticky;
`endif

    // A full slot still counts as free when it is being drained this cycle.
    assign elig0 = !rst && req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1 = !rst && req1_valid && (!rsp1_valid || rsp1_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= PRI0;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (grant0)      state_next = PRI1;
        else if (grant1) state_next = PRI0;
    end

    always_comb begin
        grant0 = elig0 && (state == PRI0 || !elig1);
        grant1 = elig1 && (state == PRI1 || !elig0);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sh_data  = grant1 ? req1_data  : req0_data;
    assign sh_shamt = grant1 ? req1_shamt : req0_shamt;
    assign sh_tag   = grant1 ? req1_tag   : req0_tag;

    barrel_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_shifter (
        .data   (sh_data),
        .shamt  (sh_shamt),
        .result (sh_result)
`ifdef SHIFTER_ARB_STICKY_EN
        ,
        .sticky (sh_sticky)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_tag   <= '0;
`ifdef SHIFTER_ARB_STICKY_EN
            rsp0_sticky <= 1'b0;
`endif
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= sh_result;
            rsp0_tag   <= sh_tag;
`ifdef SHIFTER_ARB_STICKY_EN
            rsp0_sticky <= sh_sticky;
`endif
        end else if (rsp0_valid && rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_tag   <= '0;
`ifdef SHIFTER_ARB_STICKY_EN
            rsp1_sticky <= 1'b0;
`endif
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= sh_result;
            rsp1_tag   <= sh_tag;
`ifdef SHIFTER_ARB_STICKY_EN
            rsp1_sticky <= sh_sticky;
`endif
        end else if (rsp1_valid && rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed, table-driven bench for shifter_arbiter with hand-written multi-cycle sequences.
// Sticky outputs are checked only when SHIFTER_ARB_STICKY_EN is defined.

module tb_shifter_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [22:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [22:0] rsp0_data, rsp1_data;
    logic [3:0]  rsp0_tag, rsp1_tag;
`ifdef SHIFTER_ARB_STICKY_EN
    logic        rsp0_sticky, rsp1_sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shifter_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_tag   (req1_tag),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_tag   (rsp0_tag),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_tag   (rsp1_tag)
`ifdef SHIFTER_ARB_STICKY_EN
        ,
        .rsp0_sticky (rsp0_sticky),
        .rsp1_sticky (rsp1_sticky)
`endif
    );

    typedef struct {
        logic        r0v; logic [22:0] r0d; logic [4:0] r0s; logic [3:0] r0t;
        logic        r1v; logic [22:0] r1d; logic [4:0] r1s; logic [3:0] r1t;
        logic        c0r; logic        c1r;
        logic        e_rdy0; logic e_rdy1;
        logic        e_v0; logic [22:0] e_d0; logic [3:0] e_t0; logic e_k0;
        logic        e_v1; logic [22:0] e_d1; logic [3:0] e_t1; logic e_k1;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_data = '0; req0_shamt = '0; req0_tag = '0;
        req1_valid = 0; req1_data = '0; req1_shamt = '0; req1_tag = '0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic set_req0(input logic v, input logic [22:0] d, input logic [4:0] s, input logic [3:0] t);
        req0_valid = v; req0_data = d; req0_shamt = s; req0_tag = t;
    endtask

    task automatic set_req1(input logic v, input logic [22:0] d, input logic [4:0] s, input logic [3:0] t);
        req1_valid = v; req1_data = d; req1_shamt = s; req1_tag = t;
    endtask

    initial begin
        vecs[0] = '{1,23'h7FFFFF,5'd4,4'd3, 0,23'h0,5'd0,4'd0, 1,1, 1,0, 1,23'h07FFFF,4'd3,1, 0,23'h0,4'd0,0};
        vecs[1] = '{1,23'h400000,5'd1,4'd1, 1,23'h000F00,5'd8,4'd2, 1,1, 0,1, 0,23'h07FFFF,4'd3,1, 1,23'h00000F,4'd2,0};
        vecs[2] = '{1,23'h400000,5'd1,4'd1, 1,23'h000F00,5'd8,4'd2, 1,1, 1,0, 1,23'h200000,4'd1,0, 0,23'h00000F,4'd2,0};
        vecs[3] = '{1,23'h400001,5'd0,4'd4, 0,23'h0,5'd0,4'd0, 1,1, 1,0, 1,23'h400001,4'd4,0, 0,23'h00000F,4'd2,0};
        vecs[4] = '{1,23'h400001,5'd22,4'd5, 0,23'h0,5'd0,4'd0, 1,1, 1,0, 1,23'h000001,4'd5,1, 0,23'h00000F,4'd2,0};
        vecs[5] = '{1,23'h400001,5'd23,4'd6, 0,23'h0,5'd0,4'd0, 1,1, 1,0, 1,23'h000000,4'd6,1, 0,23'h00000F,4'd2,0};
        vecs[6] = '{1,23'h400001,5'd31,4'd7, 0,23'h0,5'd0,4'd0, 1,1, 1,0, 1,23'h000000,4'd7,1, 0,23'h00000F,4'd2,0};
        vecs[7] = '{1,23'h400001,5'd0,4'd8, 1,23'h001234,5'd0,4'd9, 0,1, 0,1, 1,23'h000000,4'd7,1, 1,23'h001234,4'd9,0};
        vecs[8] = '{0,23'h0,5'd0,4'd0, 0,23'h0,5'd0,4'd0, 1,1, 0,0, 0,23'h000000,4'd7,1, 0,23'h001234,4'd9,0};

        // Reset state, with requests present during reset.
        rst = 1;
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        tick();
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        check("rst_v0", rsp0_valid, 0);
        check("rst_v1", rsp1_valid, 0);
        check("rst_d0", rsp0_data, 0);
        check("rst_t1", rsp1_tag, 0);
        tick();
        rst = 0;
        idle_inputs();

        // Table: each vector drives one cycle from the reset state onward.
        for (int i = 0; i < 9; i++) begin
            set_req0(vecs[i].r0v, vecs[i].r0d, vecs[i].r0s, vecs[i].r0t);
            set_req1(vecs[i].r1v, vecs[i].r1d, vecs[i].r1s, vecs[i].r1t);
            rsp0_ready = vecs[i].c0r; rsp1_ready = vecs[i].c1r;
            #1;
            check($sformatf("v%0d_rdy0", i), req0_ready, vecs[i].e_rdy0);
            check($sformatf("v%0d_rdy1", i), req1_ready, vecs[i].e_rdy1);
            tick();
            check($sformatf("v%0d_v0", i), rsp0_valid, vecs[i].e_v0);
            check($sformatf("v%0d_d0", i), rsp0_data, vecs[i].e_d0);
            check($sformatf("v%0d_t0", i), rsp0_tag, vecs[i].e_t0);
            check($sformatf("v%0d_v1", i), rsp1_valid, vecs[i].e_v1);
            check($sformatf("v%0d_d1", i), rsp1_data, vecs[i].e_d1);
            check($sformatf("v%0d_t1", i), rsp1_tag, vecs[i].e_t1);
`ifdef SHIFTER_ARB_STICKY_EN
            check($sformatf("v%0d_k0", i), rsp0_sticky, vecs[i].e_k0);
            check($sformatf("v%0d_k1", i), rsp1_sticky, vecs[i].e_k1);
`endif
        end

        // Contention from the first post-reset cycle: grants alternate 0,1,0.
        do_reset();
        set_req0(1, 23'h400000, 5'd1, 4'd1);
        set_req1(1, 23'h000F00, 5'd8, 4'd2);
        #1;
        check("cont1_rdy0", req0_ready, 1);
        check("cont1_rdy1", req1_ready, 0);
        tick();
        check("cont1_d0", rsp0_data, 23'h200000);
        #1;
        check("cont2_rdy0", req0_ready, 0);
        check("cont2_rdy1", req1_ready, 1);
        tick();
        check("cont2_v1", rsp1_valid, 1);
        check("cont2_d1", rsp1_data, 23'h00000F);
        #1;
        check("cont3_rdy0", req0_ready, 1);
        check("cont3_rdy1", req1_ready, 0);

        // Backpressure on slot 0 while port 1 keeps flowing.
        do_reset();
        rsp0_ready = 0;
        set_req0(1, 23'h001234, 5'd0, 4'd10);
        tick();
        set_req0(1, 23'h00FFFF, 5'd0, 4'd11);
        for (int i = 0; i < 5; i++) begin
            set_req1(1, 23'h000100, 5'd4, 4'(i));
            #1;
            check($sformatf("bp%0d_rdy0", i), req0_ready, 0);
            check($sformatf("bp%0d_rdy1", i), req1_ready, 1);
            tick();
            check($sformatf("bp%0d_v0", i), rsp0_valid, 1);
            check($sformatf("bp%0d_d0", i), rsp0_data, 23'h001234);
            check($sformatf("bp%0d_t0", i), rsp0_tag, 4'd10);
            check($sformatf("bp%0d_t1", i), rsp1_tag, 4'(i));
            check($sformatf("bp%0d_d1", i), rsp1_data, 23'h000010);
        end
        rsp0_ready = 1;
        #1;
        check("bp_release_rdy0", req0_ready, 1);
        tick();
        check("bp_release_d0", rsp0_data, 23'h00FFFF);
        check("bp_release_t0", rsp0_tag, 4'd11);

        // Reset mid-operation with both slots full and port 1 preferred.
        do_reset();
        rsp0_ready = 0; rsp1_ready = 0;
        set_req1(1, 23'h000055, 5'd0, 4'd5);
        tick();
        set_req1(0, 23'h0, 5'd0, 4'd0);
        set_req0(1, 23'h0000AA, 5'd0, 4'd6);
        tick();
        check("mid_pre_v0", rsp0_valid, 1);
        check("mid_pre_v1", rsp1_valid, 1);
        rst = 1;
        set_req0(1, 23'h000111, 5'd0, 4'd1);
        set_req1(1, 23'h000222, 5'd0, 4'd2);
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        check("mid_rst_rdy0", req0_ready, 0);
        check("mid_rst_rdy1", req1_ready, 0);
        tick();
        rst = 0;
        check("mid_v0", rsp0_valid, 0);
        check("mid_v1", rsp1_valid, 0);
        check("mid_d0", rsp0_data, 0);
        check("mid_d1", rsp1_data, 0);
        check("mid_t0", rsp0_tag, 0);
        check("mid_t1", rsp1_tag, 0);
        #1;
        check("mid_after_rdy0", req0_ready, 1);
        check("mid_after_rdy1", req1_ready, 0);
        tick();
        check("mid_after_d0", rsp0_data, 23'h000111);

        // Drain-and-refill on slot 0 with no bubble.
        do_reset();
        set_req0(1, 23'h0000FF, 5'd4, 4'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            req0_tag = 4'(i);
            #1;
            check($sformatf("dr%0d_rdy0", i), req0_ready, 1);
            tick();
            check($sformatf("dr%0d_v0", i), rsp0_valid, 1);
            check($sformatf("dr%0d_d0", i), rsp0_data, 23'h00000F);
            check($sformatf("dr%0d_t0", i), rsp0_tag, 4'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one combinational Barrel_Shifter (23-bit logical right shift) between two requesters in the FPU.
  - Requester 0 is the add/sub exponent-alignment path.
  - Requester 1 is the normalisation/denormal path.
- Round-robin arbitration, valid/ready handshake per port, one registered result slot per requester.
- Throughput up to one shift per clock in aggregate.

Parameters:
- DATA_W, 23, mantissa width fed to Barrel_Shifter; fixed by the shifter, not to be overridden.
- SHAMT_W, 5, shift amount width.
- TAG_W, 4, opaque requester tag carried through with the result.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 presents a shift
- req0_ready  output  1  requester 0 shift accepted this cycle
- req0_data  input  DATA_W  operand for requester 0
- req0_shamt  input  SHAMT_W  right-shift amount for requester 0
- req0_tag  input  TAG_W  tag for requester 0
- req1_valid, req1_ready, req1_data, req1_shamt, req1_tag  same as above, requester 1
- rsp0_valid  output  1  result slot 0 holds a result
- rsp0_ready  input  1  consumer 0 takes the result
- rsp0_data  output  DATA_W  req0_data >> req0_shamt
- rsp0_tag  output  TAG_W  tag of that request
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_tag  same as above, requester 1

Behaviour:
- Instantiates exactly one Barrel_Shifter. Its inputs are muxed from the granted requester; result = data >> shamt, zero-fill.
  - shamt >= 23 (23..31) yields 0.
  - shamt = 0 passes data through unchanged.
- Arbiter FSM, 2 states: PRI0 (port 0 preferred) and PRI1 (port 1 preferred). Reset state is PRI0.
- eligible_i = reqi_valid && slot_free_i, where slot_free_i = !rspi_valid || rspi_ready (drain-and-refill in the same cycle allowed).
- Grant rules, combinational, one grant per cycle:
  - Both eligible: grant the preferred port.
  - Only one eligible: grant it regardless of preference.
  - None eligible: no grant.
- reqi_ready = grant_i. Ready may depend on valid; valid must never depend on ready.
- FSM transitions:
  - Grant to 0 -> PRI1.
  - Grant to 1 -> PRI0.
  - No grant -> hold state.
- Latency: a request accepted at edge N gives rspi_valid=1 with data/tag after edge N; observable in the cycle following the handshake.
- Slot i update at each edge:
  - If grant_i: load shifter result and tag, set valid.
  - Else if rspi_valid && rspi_ready: clear valid; data/tag may hold.
  - Else: hold.
- While rspi_valid && !rspi_ready, rspi_data and rspi_tag must stay stable. The blocked port sees reqi_ready=0; the other port is unaffected.
- Reset values (after any edge with rst=1):
  - rsp0_valid = rsp1_valid = 0.
  - rsp*_data = 0, rsp*_tag = 0.
  - FSM in PRI0.
  - req0_ready and req1_ready forced 0 while rst=1.
- Reset mid-operation: pending results are discarded with no handshake; the request on the bus in a reset cycle is not accepted.
- No X propagation: rsp outputs are driven from registers only.

Optional Feature:
- Macro SHIFTER_ARB_STICKY_EN.
- When defined, adds outputs rsp0_sticky and rsp1_sticky (1 bit each), registered alongside the data.
  - sticky = OR of all bits shifted out: |(data & ((1<<shamt)-1)) for shamt < 23; |data for shamt >= 23; 0 for shamt = 0.
  - Same reset (0), hold and stability rules as rsp data.
- When not defined: the ports do not exist and no sticky logic is built.

Test Plan:
- Single request: after reset, req0 data 23'h7FFFFF, shamt 4, tag 3, rsp0_ready=1 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, data 23'h07FFFF, tag 3, sticky 1 (with _EN).
- Contention: both valid from the first post-reset cycle; req0 = 23'h400000>>1, req1 = 23'h000F00>>8 -> cycle 1 grants port 0 (rsp0 = 23'h200000); cycle 2 grants port 1 (rsp1 = 23'h00000F); FSM alternates thereafter.
- Backpressure: rsp0_valid with data 23'h001234 and rsp0_ready=0 for 5 cycles, req0 and req1 valid -> req0_ready=0 and rsp0_data stable all 5 cycles; req1 granted every cycle; raising rsp0_ready lets req0 be accepted that same cycle.
- Boundary amounts: data 23'h400001 with shamt 0 / 22 / 23 / 31 -> 23'h400001 / 23'h000001 / 0 / 0; sticky 0 / 1 / 1 / 1.
- Reset mid-operation: rst=1 for one cycle while rsp0_valid=1, rsp1_valid=1, FSM in PRI1 -> next cycle both valids 0, data/tag 0, both readys 0 during rst; a subsequent simultaneous request grants port 0 first.
- Drain-and-refill: rsp0_valid=1, rsp0_ready=1, req0_valid=1 (data 23'h0000FF, shamt 4) for 4 consecutive cycles -> req0_ready=1 every cycle; rsp0_data = 23'h00000F with no bubble; tags update each cycle.
